// File: rtl/stream_word_packer_if.sv
// stream_word_packer_if: byte-in / word-out stream bundle for stream_word_packer
// Signals: in_data/in_valid/flush (byte side, no backpressure), out_data/out_keep/out_valid/out_ready
//   (word ready/valid side), level (FIFO occupancy), overflow (sticky drop flag).
// slave is the packer's view, master is the environment's view.
interface stream_word_packer_if #(
  parameter int FIFO_DEPTH = 4
);
  logic [7:0] in_data;
  logic in_valid;
  logic flush;
  logic [31:0] out_data;
  logic [3:0] out_keep;
  logic out_valid;
  logic out_ready;
  logic [$clog2(FIFO_DEPTH):0] level;
  logic overflow;
  modport master (
    output in_data, in_valid, flush, out_ready,
    input out_data, out_keep, out_valid, level, overflow
  );
  modport slave (
    input in_data, in_valid, flush, out_ready,
    output out_data, out_keep, out_valid, level, overflow
  );
endinterface

// File: rtl/stream_word_packer.sv
// stream_word_packer: packs a byte stream into 32-bit little-endian words with a keep mask, buffered in a word FIFO
// Ports: clk; rst (synchronous, active-high); bus (slave modport): in_data/in_valid/flush byte input,
//   out_data/out_keep/out_valid/out_ready word output, level = FIFO occupancy, overflow = sticky dropped-word flag.
module stream_word_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  stream_word_packer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  logic [1:0] cnt;
  logic [2:0] cnt_next;
  logic [31:0] asm_word;
  logic [31:0] asm_next;
  logic [3:0] keep;
  logic push;
  logic pop;
  logic push_ok;
  logic not_empty;
  logic [35:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic [LW-1:0] used;
  logic ovf;
  always_comb begin
    asm_next = asm_word;
    if (bus.in_valid) asm_next[{cnt, 3'b000} +: 8] = bus.in_data;
  end
  assign cnt_next = {1'b0, cnt} + {2'b00, bus.in_valid};
  // cnt_next==4 is a completed word; any nonzero count with flush is a partial emit
  assign push = cnt_next[2] | (bus.flush & (cnt_next != 3'd0));
  assign keep = 4'((5'd1 << cnt_next) - 5'd1);
  assign not_empty = used != '0;
  assign pop = not_empty & bus.out_ready;
  // a full FIFO still accepts a word when its head leaves on the same edge
  assign push_ok = push & ((used != LW'(FIFO_DEPTH)) | pop);
  assign bus.out_valid = not_empty;
  assign bus.out_data = not_empty ? mem[rd][31:0] : '0;
  assign bus.out_keep = not_empty ? mem[rd][35:32] : '0;
  assign bus.level = used;
  assign bus.overflow = ovf;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      asm_word <= '0;
      rd <= '0;
      wr <= '0;
      used <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= push ? 2'd0 : cnt_next[1:0];
      asm_word <= push ? '0 : asm_next;
      wr <= wr + AW'(push_ok);
      rd <= rd + AW'(pop);
      used <= used + LW'(push_ok) - LW'(pop);
      if (push & ~push_ok) ovf <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr] <= {keep, asm_next};
  end
endmodule

// File: tb/tb_stream_word_packer.sv
// tb_stream_word_packer: directed and randomized checks of stream_word_packer against a byte/word queue model
module tb_stream_word_packer;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int chk = 0;
  int err = 0;
  stream_word_packer_if #(.FIFO_DEPTH(D)) bus ();
  stream_word_packer #(.FIFO_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  logic [7:0] bq[$];
  logic [35:0] mq[$];
  logic movf = 1'b0;
  task automatic tick();
    logic pop;
    logic [35:0] w;
    bit do_push;
    @(posedge clk);
    if (rst) begin
      bq.delete();
      mq.delete();
      movf = 1'b0;
    end else begin
      pop = (mq.size() > 0) && bus.out_ready;
      do_push = 0;
      w = '0;
      if (bus.in_valid) bq.push_back(bus.in_data);
      if (bq.size() == 4 || (bus.flush && bq.size() > 0)) begin
        for (int i = 0; i < bq.size(); i++) begin
          w[8*i +: 8] = bq[i];
          w[32+i] = 1'b1;
        end
        if (mq.size() < D || pop) do_push = 1;
        else movf = 1'b1;
        bq.delete();
      end
      if (pop) void'(mq.pop_front());
      if (do_push) mq.push_back(w);
    end
    #1;
  endtask
  task automatic send(input logic [7:0] b, input logic f);
    bus.in_valid = 1'b1;
    bus.in_data = b;
    bus.flush = f;
    tick();
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    bus.in_valid = 1'b1;
    bus.in_data = 8'h5A;
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    chk++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
    chk++; if (bus.out_data !== 32'h0) begin err++; $display("FAIL reset_data got %h exp 0", bus.out_data); end
    chk++; if (bus.out_keep !== 4'h0) begin err++; $display("FAIL reset_keep got %h exp 0", bus.out_keep); end
    chk++; if (bus.level !== 3'd0) begin err++; $display("FAIL reset_level got %0d exp 0", bus.level); end
    chk++; if (bus.overflow !== 1'b0) begin err++; $display("FAIL reset_overflow got %b exp 0", bus.overflow); end
  endtask
  task automatic test_full_word();
    bus.out_ready = 1'b1;
    send(8'h10, 0);
    send(8'h20, 0);
    send(8'hFF, 0);
    chk++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL word_early_valid got %b exp 0", bus.out_valid); end
    send(8'h01, 0);
    chk++; if (bus.out_valid !== 1'b1) begin err++; $display("FAIL word_valid got %b exp 1", bus.out_valid); end
    chk++; if (bus.out_data !== 32'h01FF2010) begin err++; $display("FAIL word_data got %h exp 01ff2010", bus.out_data); end
    chk++; if (bus.out_keep !== 4'hF) begin err++; $display("FAIL word_keep got %h exp f", bus.out_keep); end
    tick();
    chk++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL word_popped got %b exp 0", bus.out_valid); end
  endtask
  task automatic test_flush_alone();
    bus.out_ready = 1'b0;
    send(8'hAA, 0);
    send(8'hBB, 0);
    send(8'hCC, 0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk++; if (bus.out_data !== 32'h00CCBBAA) begin err++; $display("FAIL flush3_data got %h exp 00ccbbaa", bus.out_data); end
    chk++; if (bus.out_keep !== 4'h7) begin err++; $display("FAIL flush3_keep got %h exp 7", bus.out_keep); end
    bus.out_ready = 1'b1;
    tick();
  endtask
  task automatic test_flush_with_byte();
    bus.out_ready = 1'b0;
    send(8'h44, 0);
    send(8'h55, 1);
    chk++; if (bus.out_data !== 32'h00005544) begin err++; $display("FAIL flush2_data got %h exp 00005544", bus.out_data); end
    chk++; if (bus.out_keep !== 4'h3) begin err++; $display("FAIL flush2_keep got %h exp 3", bus.out_keep); end
    chk++; if (bus.level !== 3'd1) begin err++; $display("FAIL flush2_level got %0d exp 1", bus.level); end
    bus.out_ready = 1'b1;
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL flush_noop_valid got %b exp 0", bus.out_valid); end
    chk++; if (bus.level !== 3'd0) begin err++; $display("FAIL flush_noop_level got %0d exp 0", bus.level); end
    send(8'h9C, 0);
    send(8'h9D, 0);
    send(8'h9E, 0);
    send(8'h9F, 1);
    chk++; if (bus.out_keep !== 4'hF || bus.level !== 3'd1) begin err++; $display("FAIL flush4_single got keep %h level %0d exp f 1", bus.out_keep, bus.level); end
    tick();
  endtask
  task automatic test_overflow();
    logic [31:0] words [D+1];
    do_reset();
    bus.out_ready = 1'b0;
    for (int w = 0; w <= D; w++) begin
      words[w] = $urandom;
      for (int k = 0; k < 4; k++) send(words[w][8*k +: 8], 0);
    end
    chk++; if (bus.level !== 3'(D)) begin err++; $display("FAIL ovf_level got %0d exp %0d", bus.level, D); end
    chk++; if (bus.overflow !== 1'b1) begin err++; $display("FAIL ovf_flag got %b exp 1", bus.overflow); end
    tick();
    chk++; if (bus.out_data !== words[0]) begin err++; $display("FAIL ovf_hold got %h exp %h", bus.out_data, words[0]); end
    bus.out_ready = 1'b1;
    for (int w = 0; w < D; w++) begin
      chk++; if (bus.out_data !== words[w] || bus.out_keep !== 4'hF) begin err++; $display("FAIL ovf_drain%0d got %h/%h exp %h/f", w, bus.out_data, bus.out_keep, words[w]); end
      tick();
    end
    chk++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL ovf_empty got %b exp 0", bus.out_valid); end
    chk++; if (bus.overflow !== 1'b1) begin err++; $display("FAIL ovf_sticky got %b exp 1", bus.overflow); end
  endtask
  task automatic test_full_pop_push();
    logic [31:0] words [D+1];
    do_reset();
    bus.out_ready = 1'b0;
    for (int w = 0; w <= D; w++) begin
      words[w] = $urandom;
      for (int k = 0; k < 4; k++) begin
        if (w == D && k == 3) bus.out_ready = 1'b1;
        send(words[w][8*k +: 8], 0);
        bus.out_ready = 1'b0;
      end
    end
    chk++; if (bus.level !== 3'(D)) begin err++; $display("FAIL fullpp_level got %0d exp %0d", bus.level, D); end
    chk++; if (bus.overflow !== 1'b0) begin err++; $display("FAIL fullpp_overflow got %b exp 0", bus.overflow); end
    chk++; if (bus.out_data !== words[1]) begin err++; $display("FAIL fullpp_head got %h exp %h", bus.out_data, words[1]); end
    bus.out_ready = 1'b1;
    for (int w = 1; w <= D; w++) begin
      chk++; if (bus.out_data !== words[w]) begin err++; $display("FAIL fullpp_drain%0d got %h exp %h", w, bus.out_data, words[w]); end
      tick();
    end
  endtask
  task automatic test_reset_mid_word();
    bus.out_ready = 1'b0;
    send(8'h77, 0);
    send(8'h88, 0);
    do_reset();
    send(8'h01, 0);
    send(8'h02, 0);
    send(8'h03, 0);
    send(8'h04, 0);
    chk++; if (bus.out_data !== 32'h04030201) begin err++; $display("FAIL midrst_data got %h exp 04030201", bus.out_data); end
    chk++; if (bus.out_keep !== 4'hF) begin err++; $display("FAIL midrst_keep got %h exp f", bus.out_keep); end
    chk++; if (bus.overflow !== 1'b0 || bus.level !== 3'd1) begin err++; $display("FAIL midrst_state got ovf %b level %0d exp 0 1", bus.overflow, bus.level); end
  endtask
  task automatic test_random();
    logic [35:0] h;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data = 8'($urandom);
      bus.flush = ($urandom_range(0, 5) == 0);
      bus.out_ready = (n % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick();
      h = (mq.size() > 0) ? mq[0] : 36'h0;
      chk++; if (bus.out_valid !== (mq.size() > 0)) begin err++; $display("FAIL rnd_valid n=%0d got %b exp %b", n, bus.out_valid, mq.size() > 0); end
      chk++; if (bus.out_data !== h[31:0]) begin err++; $display("FAIL rnd_data n=%0d got %h exp %h", n, bus.out_data, h[31:0]); end
      chk++; if (bus.out_keep !== h[35:32]) begin err++; $display("FAIL rnd_keep n=%0d got %h exp %h", n, bus.out_keep, h[35:32]); end
      chk++; if (bus.level !== 3'(mq.size())) begin err++; $display("FAIL rnd_level n=%0d got %0d exp %0d", n, bus.level, mq.size()); end
      chk++; if (bus.overflow !== movf) begin err++; $display("FAIL rnd_overflow n=%0d got %b exp %b", n, bus.overflow, movf); end
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
  endtask
  initial begin
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_full_word();
    test_flush_alone();
    test_flush_with_byte();
    test_overflow();
    test_full_pop_push();
    test_reset_mid_word();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
